// File: rtl/ahfp_float_2_fixed_pipe.sv
// Purpose: IEEE-754 single to signed fixed-point (Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS) with RNE/trunc, saturation, flags.
// Latency: 2 cycles (decode/shift register, round/saturate output register), 1 result per cycle.
// Backpressure: valid/ready; each stage loads when empty or draining; outputs hold while out_valid && !out_ready.
// Ports: clk/rst_n; in_valid/in_ready/in_data/rnd_mode (input side);
//        out_valid/out_ready/out_data/out_ovf/out_nan/out_inexact (result side);
//        sts_clear/sts_flags = sticky {nan, ovf, inexact} over delivered results.
module ahfp_float_2_fixed_pipe #(
  parameter int OUT_WIDTH = 32,
  parameter int FRAC_BITS = 29
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 out_nan,
  output logic                 out_inexact,
  input  logic                 sts_clear,
  output logic [2:0]           sts_flags
);

  localparam int W  = OUT_WIDTH;
  // Wide enough to hold the 24-bit significand shifted left by up to W-1.
  localparam int FW = OUT_WIDTH + 24;
  localparam logic signed [10:0] W_S = 11'(OUT_WIDTH);
  localparam logic signed [10:0] F_S = 11'(FRAC_BITS);
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

  // ---------------- handshake ----------------
  logic s1_valid;
  logic adv2;   // output register may take a new word this cycle
  logic adv1;   // stage-1 register may take a new word this cycle

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // ---------------- stage 1 decode / shift ----------------
  logic [7:0]         e;
  logic [22:0]        mfrac;
  logic [23:0]        sig;
  logic signed [10:0] sh;
  logic [10:0]        rsh;
  logic [FW-1:0]      full;
  logic [48:0]        rext;
  logic [W-1:0]       d_mag;
  logic               d_big, d_guard, d_sticky, d_nan;

  assign e     = in_data[30:23];
  assign mfrac = in_data[22:0];
  assign sig   = {1'b1, mfrac};
  assign sh    = $signed({3'b000, e}) - 11'sd150 + F_S;
  assign rsh   = 11'(-sh);

  always_comb begin
    d_mag    = '0;
    d_big    = 1'b0;   // magnitude >= 2^W, i.e. certainly saturates
    d_guard  = 1'b0;
    d_sticky = 1'b0;
    d_nan    = 1'b0;
    full     = '0;
    rext     = '0;
    if (e == 8'd0) begin
      // Zero/denormal flush: value is far below 1 LSB, only inexact survives.
      d_sticky = |mfrac;
    end else if (e == 8'hFF) begin
      if (mfrac != 23'd0) d_nan = 1'b1;
      else                d_big = 1'b1;
    end else if (sh >= 11'sd0) begin
      if (sh >= W_S) begin
        d_big = 1'b1;
      end else begin
        full  = {{W{1'b0}}, sig} << sh[5:0];
        d_big = |full[FW-1:W];
        d_mag = full[W-1:0];
      end
    end else begin
      if (rsh >= 11'd49) begin
        // Everything shifts past the guard position; hidden bit makes sticky 1.
        d_sticky = 1'b1;
      end else begin
        // Significand sits above 25 extension bits: [24] is guard, [23:0] sticky.
        rext     = {sig, 25'd0} >> rsh[5:0];
        full     = {{W{1'b0}}, rext[48:25]};
        d_big    = |full[FW-1:W];
        d_mag    = full[W-1:0];
        d_guard  = rext[24];
        d_sticky = |rext[23:0];
      end
    end
  end

  logic [W-1:0] s1_mag;
  logic         s1_sign, s1_big, s1_guard, s1_sticky, s1_nan, s1_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mag    <= '0;
      s1_sign   <= 1'b0;
      s1_big    <= 1'b0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_nan    <= 1'b0;
      s1_rnd    <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mag    <= d_mag;
        s1_sign   <= in_data[31];
        s1_big    <= d_big;
        s1_guard  <= d_guard;
        s1_sticky <= d_sticky;
        s1_nan    <= d_nan;
        s1_rnd    <= rnd_mode;
      end
    end
  end

  // ---------------- stage 2 round / negate / saturate ----------------
  logic         inc;
  logic [W:0]   rounded;
  logic         big2;
  logic         ovf_c;
  logic [W-1:0] res_c;

  assign inc     = s1_rnd & s1_guard & (s1_sticky | s1_mag[0]);
  assign rounded = {1'b0, s1_mag} + {{W{1'b0}}, inc};
  // Rounding carry out of the top bit also means the magnitude reached 2^W.
  assign big2    = s1_big | rounded[W];

  always_comb begin
    if (s1_sign) ovf_c = big2 | (rounded[W-1] & (|rounded[W-2:0]));
    else         ovf_c = big2 | rounded[W-1];
    if (ovf_c)        res_c = s1_sign ? NEG_MIN : POS_MAX;
    else if (s1_sign) res_c = -rounded[W-1:0];
    else              res_c = rounded[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_nan     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= res_c;
        out_ovf     <= ovf_c;
        out_nan     <= s1_nan;
        out_inexact <= s1_guard | s1_sticky;
      end
    end
  end

  // ---------------- sticky status ----------------
  // A delivered result's flags take priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_flags <= 3'b000;
    end else if (out_valid && out_ready) begin
      sts_flags <= (sts_clear ? 3'b000 : sts_flags) | {out_nan, out_ovf, out_inexact};
    end else if (sts_clear) begin
      sts_flags <= 3'b000;
    end
  end

endmodule
